// File: rtl/signed_fixed_point_mac_lanes.sv
`default_nettype none
// ============================================================================
// Module   : signed_fixed_point_mac_lanes
// Purpose  : Multi-lane pipelined signed fixed-point multiplier. Each lane
//            forms the full-width signed product, rescales it by FRAC_BITS
//            (floor, or round-half-up when FXP_MUL_ROUND_EN is defined),
//            saturates it to PRODUCT_WIDTH and flags the clamp. A single
//            global enable stalls every stage under output backpressure.
// Ports    : clk_in          - clock, rising edge
//            rst_in          - asynchronous active-high reset
//            in_valid_in     - input beat valid
//            in_ready_out    - input beat accepted this cycle
//            multiplicand_in - NUM_LANES packed signed operands
//            multiplier_in   - NUM_LANES packed signed operands
//            out_valid_out   - output beat valid
//            out_ready_in    - downstream accepts output beat
//            product_out     - NUM_LANES packed saturated products
//            lane_sat_out    - per-lane saturation flags of the output beat
//            sat_sticky_out  - a saturated beat transferred since last clear
//            sat_clear_in    - synchronous clear of sat_sticky_out
// Macro    : FXP_MUL_ROUND_EN - enable round-half-up before the shift
// Revision : 1.0 - initial release
// ============================================================================
module signed_fixed_point_mac_lanes #(
    parameter int DATA_WIDTH    = 16,
    parameter int FRAC_BITS     = 10,
    parameter int NUM_LANES     = 4,
    parameter int PIPE_STAGES   = 2,
    parameter int PRODUCT_WIDTH = DATA_WIDTH
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               in_valid_in,
    output logic                               in_ready_out,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]    multiplicand_in,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]    multiplier_in,
    output logic                               out_valid_out,
    input  logic                               out_ready_in,
    output logic [NUM_LANES*PRODUCT_WIDTH-1:0] product_out,
    output logic [NUM_LANES-1:0]               lane_sat_out,
    output logic                               sat_sticky_out,
    input  logic                               sat_clear_in
);

    localparam int c_raw_width = 2 * DATA_WIDTH;
    // One guard bit above the raw product so the rounding add cannot wrap.
    localparam int c_ext_width = c_raw_width + 1;

    localparam logic signed [c_ext_width-1:0] c_sat_max =
        {{(c_ext_width-PRODUCT_WIDTH+1){1'b0}}, {(PRODUCT_WIDTH-1){1'b1}}};
    localparam logic signed [c_ext_width-1:0] c_sat_min =
        {{(c_ext_width-PRODUCT_WIDTH+1){1'b1}}, {(PRODUCT_WIDTH-1){1'b0}}};
    localparam logic [PRODUCT_WIDTH-1:0] c_lane_max = {1'b0, {(PRODUCT_WIDTH-1){1'b1}}};
    localparam logic [PRODUCT_WIDTH-1:0] c_lane_min = {1'b1, {(PRODUCT_WIDTH-1){1'b0}}};

    logic                                w_en;
    logic [NUM_LANES*c_raw_width-1:0]    w_mul;
    logic [NUM_LANES*c_raw_width-1:0]    r_s1_prod;
    logic                                r_s1_valid;
    logic [NUM_LANES*PRODUCT_WIDTH-1:0]  w_rect;
    logic [NUM_LANES-1:0]                w_sat;

    // Whole pipeline advances together; ready depends combinationally on
    // out_ready_in so a held output beat can leave and be replaced in one cycle.
    assign w_en         = !out_valid_out || out_ready_in;
    assign in_ready_out = w_en;

    // ------------------------------------------------------------------------
    // Per-lane multiply (before stage 1) and rectification (after stage 1)
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        logic signed [c_raw_width-1:0] w_a;
        logic signed [c_raw_width-1:0] w_b;
        logic signed [c_raw_width-1:0] w_raw;
        logic signed [c_ext_width-1:0] w_raw_ext;
        logic signed [c_ext_width-1:0] w_shifted;
        logic                          w_over;
        logic                          w_under;

        // Sign-extend to full product width so the low 2*DATA_WIDTH bits of
        // the multiply are the exact signed product.
        assign w_a = {{DATA_WIDTH{multiplicand_in[gi*DATA_WIDTH+DATA_WIDTH-1]}},
                      multiplicand_in[gi*DATA_WIDTH +: DATA_WIDTH]};
        assign w_b = {{DATA_WIDTH{multiplier_in[gi*DATA_WIDTH+DATA_WIDTH-1]}},
                      multiplier_in[gi*DATA_WIDTH +: DATA_WIDTH]};
        assign w_mul[gi*c_raw_width +: c_raw_width] = w_a * w_b;

        assign w_raw     = r_s1_prod[gi*c_raw_width +: c_raw_width];
        assign w_raw_ext = {w_raw[c_raw_width-1], w_raw};

`ifdef FXP_MUL_ROUND_EN
        localparam logic signed [c_ext_width-1:0] c_round_half =
            {{(c_ext_width-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);
        logic signed [c_ext_width-1:0] w_rounded;
        assign w_rounded = w_raw_ext + c_round_half;
        assign w_shifted = w_rounded >>> FRAC_BITS;
`else
        assign w_shifted = w_raw_ext >>> FRAC_BITS;
`endif

        assign w_over  = (w_shifted > c_sat_max);
        assign w_under = (w_shifted < c_sat_min);
        assign w_rect[gi*PRODUCT_WIDTH +: PRODUCT_WIDTH] =
            w_over  ? c_lane_max :
            w_under ? c_lane_min :
                      w_shifted[PRODUCT_WIDTH-1:0];
        assign w_sat[gi] = w_over | w_under;
    end

    // ------------------------------------------------------------------------
    // Stage 1: raw products. Bubbles still load data (don't-care) for simplicity.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_s1_valid <= 1'b0;
            r_s1_prod  <= '0;
        end else if (w_en) begin
            r_s1_valid <= in_valid_in;
            r_s1_prod  <= w_mul;
        end
    end

    // ------------------------------------------------------------------------
    // Stages 2..PIPE_STAGES: rectified lanes, flags and valid
    // ------------------------------------------------------------------------
    if (PIPE_STAGES == 1) begin : g_single_stage
        assign out_valid_out = r_s1_valid;
        assign product_out   = w_rect;
        assign lane_sat_out  = w_sat;
    end else begin : g_multi_stage
        logic [NUM_LANES*PRODUCT_WIDTH-1:0] r_data  [PIPE_STAGES-1];
        logic [NUM_LANES-1:0]               r_sat   [PIPE_STAGES-1];
        logic [PIPE_STAGES-2:0]             r_valid;

        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                r_valid <= '0;
                for (int s = 0; s < PIPE_STAGES - 1; s++) begin
                    r_data[s] <= '0;
                    r_sat[s]  <= '0;
                end
            end else if (w_en) begin
                r_valid[0] <= r_s1_valid;
                r_data[0]  <= w_rect;
                r_sat[0]   <= w_sat;
                for (int s = 1; s < PIPE_STAGES - 1; s++) begin
                    r_valid[s] <= r_valid[s-1];
                    r_data[s]  <= r_data[s-1];
                    r_sat[s]   <= r_sat[s-1];
                end
            end
        end

        assign out_valid_out = r_valid[PIPE_STAGES-2];
        assign product_out   = r_data[PIPE_STAGES-2];
        assign lane_sat_out  = r_sat[PIPE_STAGES-2];
    end

    // ------------------------------------------------------------------------
    // Sticky saturation status: a saturated transfer beats a same-cycle clear.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sat_sticky_out <= 1'b0;
        end else if (out_valid_out && out_ready_in && (|lane_sat_out)) begin
            sat_sticky_out <= 1'b1;
        end else if (sat_clear_in) begin
            sat_sticky_out <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_signed_fixed_point_mac_lanes.sv
`default_nettype none
// ============================================================================
// Module   : tb_signed_fixed_point_mac_lanes
// Purpose  : Scoreboard bench for signed_fixed_point_mac_lanes (Q5.10,
//            4 lanes, 2 stages). Expected beats come from an integer
//            reference model; a monitor pops and compares on each transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_signed_fixed_point_mac_lanes;

    localparam int DW = 16;
    localparam int FB = 10;
    localparam int L  = 4;
    localparam int PW = 16;
    localparam longint c_max_val = (longint'(1) <<< (PW - 1)) - 1;
    localparam longint c_min_val = -(longint'(1) <<< (PW - 1));

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic            in_valid_in;
    logic            in_ready_out;
    logic [L*DW-1:0] multiplicand_in;
    logic [L*DW-1:0] multiplier_in;
    logic            out_valid_out;
    logic            out_ready_in;
    logic [L*PW-1:0] product_out;
    logic [L-1:0]    lane_sat_out;
    logic            sat_sticky_out;
    logic            sat_clear_in;

    typedef struct packed {
        logic [L*PW-1:0] prod;
        logic [L-1:0]    sat;
    } exp_t;

    exp_t q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    logic            exp_sticky = 1'b0;
    logic            mon_held   = 1'b0;
    logic [L*PW-1:0] mon_hprod  = '0;
    logic [L-1:0]    mon_hsat   = '0;
    logic            mon_nxt;
    exp_t            mon_e;
    logic            rand_done;

    signed_fixed_point_mac_lanes #(
        .DATA_WIDTH    (DW),
        .FRAC_BITS     (FB),
        .NUM_LANES     (L),
        .PIPE_STAGES   (2),
        .PRODUCT_WIDTH (PW)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .in_valid_in     (in_valid_in),
        .in_ready_out    (in_ready_out),
        .multiplicand_in (multiplicand_in),
        .multiplier_in   (multiplier_in),
        .out_valid_out   (out_valid_out),
        .out_ready_in    (out_ready_in),
        .product_out     (product_out),
        .lane_sat_out    (lane_sat_out),
        .sat_sticky_out  (sat_sticky_out),
        .sat_clear_in    (sat_clear_in)
    );

    always #5 clk_in = ~clk_in;

    // Reference: exact integer product, optional +half, floor divide, clamp.
    function automatic logic [PW:0] ref_lane(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint p;
        longint r;
        logic [PW:0] res;
        p = longint'($signed(a)) * longint'($signed(b));
`ifdef FXP_MUL_ROUND_EN
        p = p + (longint'(1) <<< (FB - 1));
`endif
        r = p >>> FB;
        if (r > c_max_val)      res = {1'b1, 1'b0, {(PW-1){1'b1}}};
        else if (r < c_min_val) res = {1'b1, 1'b1, {(PW-1){1'b0}}};
        else                    res = {1'b0, r[PW-1:0]};
        return res;
    endfunction

    function automatic exp_t ref_beat(input logic [L*DW-1:0] a, input logic [L*DW-1:0] b);
        exp_t e;
        logic [PW:0] t;
        for (int i = 0; i < L; i++) begin
            t = ref_lane(a[i*DW +: DW], b[i*DW +: DW]);
            e.prod[i*PW +: PW] = t[PW-1:0];
            e.sat[i]           = t[PW];
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Present a beat and hold it until accepted; expected result queued on accept.
    task automatic send_beat(input logic [L*DW-1:0] a, input logic [L*DW-1:0] b);
        bit accepted;
        accepted        = 1'b0;
        multiplicand_in = a;
        multiplier_in   = b;
        in_valid_in     = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk_in);
            if (in_ready_out) begin
                q.push_back(ref_beat(a, b));
                @(posedge clk_in);
                #1;
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got in_ready_out=0 for 200 cycles, expected 1");
        end
    endtask

    task automatic drain();
        int n;
        for (n = 0; n < 100; n++) begin
            if (q.size() == 0) break;
            @(posedge clk_in);
            #1;
        end
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d beats pending, expected 0", q.size());
        end
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_operand();
        logic [DW-1:0] v;
        if ($urandom_range(0, 1) == 1) v = DW'($urandom);
        else                           v = DW'($urandom_range(0, 8191)) - DW'(4096);
        return v;
    endfunction

    function automatic logic [L*DW-1:0] rand_vec();
        logic [L*DW-1:0] v;
        for (int i = 0; i < L; i++) v[i*DW +: DW] = rand_operand();
        return v;
    endfunction

    // ------------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                q.delete();
                exp_sticky = 1'b0;
                mon_held   = 1'b0;
                continue;
            end
            check("in_ready", 64'(in_ready_out), 64'(!out_valid_out || out_ready_in));
            if (mon_held) begin
                check("hold_valid", 64'(out_valid_out), 64'd1);
                check("hold_product", 64'(product_out), 64'(mon_hprod));
                check("hold_sat", 64'(lane_sat_out), 64'(mon_hsat));
            end
            check("sticky", 64'(sat_sticky_out), 64'(exp_sticky));
            mon_nxt = sat_clear_in ? 1'b0 : exp_sticky;
            if (out_valid_out && out_ready_in) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_beat: got product %h, expected no output", product_out);
                end else begin
                    mon_e = q.pop_front();
                    check("product", 64'(product_out), 64'(mon_e.prod));
                    check("lane_sat", 64'(lane_sat_out), 64'(mon_e.sat));
                    if (|mon_e.sat) mon_nxt = 1'b1;
                end
            end
            exp_sticky = mon_nxt;
            mon_held   = out_valid_out && !out_ready_in;
            mon_hprod  = product_out;
            mon_hsat   = lane_sat_out;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        logic [L*DW-1:0] a;
        logic [L*DW-1:0] b;
        rst_in          = 1'b1;
        in_valid_in     = 1'b0;
        multiplicand_in = '0;
        multiplier_in   = '0;
        out_ready_in    = 1'b0;
        sat_clear_in    = 1'b0;
        rand_done       = 1'b0;

        // Reset state
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_out_valid", 64'(out_valid_out), 64'd0);
        check("rst_product", 64'(product_out), 64'd0);
        check("rst_lane_sat", 64'(lane_sat_out), 64'd0);
        check("rst_sticky", 64'(sat_sticky_out), 64'd0);
        check("rst_in_ready", 64'(in_ready_out), 64'd1);
        @(posedge clk_in);
        #1;
        rst_in       = 1'b0;
        out_ready_in = 1'b1;
        @(posedge clk_in);
        #1;

        // Basic multiply 1.5 * 2.0 with latency check
        a = {16'h0100, 16'hFF00, 16'h0C00, 16'h0600};
        b = {16'h0400, 16'h0800, 16'hFA00, 16'h0800};
        send_beat(a, b);
        in_valid_in = 1'b0;
        check("latency_not_yet", 64'(out_valid_out), 64'd0);
        @(posedge clk_in);
        #1;
        check("latency_valid", 64'(out_valid_out), 64'd1);
        check("basic_lane0", 64'(product_out[15:0]), 64'h0C00);
        check("basic_sat0", 64'(lane_sat_out[0]), 64'd0);
        drain();

        // Positive and negative saturation
        send_beat({48'h0, 16'h7FFF}, {48'h0, 16'h7FFF});
        send_beat({48'h0, 16'h8000}, {48'h0, 16'h7FFF});
        in_valid_in = 1'b0;
        drain();
        check("sat_sticky_set", 64'(sat_sticky_out), 64'd1);

        // Rounding vs truncation
        send_beat({32'h0, 16'hFFFF, 16'h0001}, {32'h0, 16'h0200, 16'h0200});
        in_valid_in = 1'b0;
        @(posedge clk_in);
        #1;
`ifdef FXP_MUL_ROUND_EN
        check("round_pos", 64'(product_out[15:0]), 64'h0001);
        check("round_neg", 64'(product_out[31:16]), 64'h0000);
`else
        check("trunc_pos", 64'(product_out[15:0]), 64'h0000);
        check("trunc_neg", 64'(product_out[31:16]), 64'hFFFF);
`endif
        drain();

        // Sticky: set wins over clear, then clear alone
        sat_clear_in = 1'b1;
        @(posedge clk_in);
        #1;
        sat_clear_in = 1'b0;
        check("sticky_cleared", 64'(sat_sticky_out), 64'd0);
        send_beat({48'h0, 16'h7FFF}, {48'h0, 16'h4000});
        in_valid_in = 1'b0;
        @(posedge clk_in);
        #1;
        sat_clear_in = 1'b1;
        @(posedge clk_in);
        #1;
        check("sticky_set_wins", 64'(sat_sticky_out), 64'd1);
        @(posedge clk_in);
        #1;
        check("sticky_clear_alone", 64'(sat_sticky_out), 64'd0);
        sat_clear_in = 1'b0;

        // Backpressure: 8 distinct beats, 3-cycle stall mid-stream
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    for (int j = 0; j < L; j++) begin
                        a[j*DW +: DW] = DW'((i * L + j + 1) * 64);
                        b[j*DW +: DW] = 16'h0400;
                    end
                    send_beat(a, b);
                end
                in_valid_in = 1'b0;
            end
            begin
                repeat (4) @(posedge clk_in);
                #1;
                out_ready_in = 1'b0;
                repeat (3) begin
                    @(negedge clk_in);
                    check("stall_in_ready", 64'(in_ready_out), 64'd0);
                    @(posedge clk_in);
                    #1;
                end
                out_ready_in = 1'b1;
            end
        join
        drain();

        // Randomized stream with random gaps and random backpressure
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid_in = 1'b0;
                        @(posedge clk_in);
                        #1;
                    end
                    send_beat(rand_vec(), rand_vec());
                end
                in_valid_in = 1'b0;
                rand_done   = 1'b1;
            end
            begin
                for (int n = 0; n < 2000 && !rand_done; n++) begin
                    out_ready_in = ($urandom_range(0, 2) != 0);
                    sat_clear_in = ($urandom_range(0, 7) == 0);
                    @(posedge clk_in);
                    #1;
                end
                out_ready_in = 1'b1;
                sat_clear_in = 1'b0;
            end
        join
        drain();

        // Reset with two beats in flight and sticky set
        send_beat({48'h0, 16'h7FFF}, {48'h0, 16'h7FFF});
        in_valid_in = 1'b0;
        drain();
        send_beat({48'h0, 16'h0600}, {48'h0, 16'h0800});
        send_beat({48'h0, 16'h0C00}, {48'h0, 16'h0400});
        in_valid_in = 1'b0;
        rst_in      = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid_out), 64'd0);
        check("midrst_product", 64'(product_out), 64'd0);
        check("midrst_sticky", 64'(sat_sticky_out), 64'd0);
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        repeat (8) @(posedge clk_in);
        #1;
        check("post_rst_no_beat", 64'(out_valid_out), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/signed_fixed_point_mac_lanes.md
# signed_fixed_point_mac_lanes

Multi-lane, pipelined signed fixed-point multiplier with a valid/ready stream interface, per-lane saturation flags and a sticky overflow status. It is the next-generation replacement for the single-lane, fixed-latency multiplier in the neuron datapath. It sits between the weight/activation fetch stage and the accumulator, and processes NUM_LANES products per accepted beat. It also applies backpressure when the accumulator stalls.

## Interface
- DATA_WIDTH, 16: width of each signed operand (two's complement).
- FRAC_BITS, 10: fractional bits of the operands and of the result (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS).
- NUM_LANES, 4: independent multiplier lanes per beat; must be ≥1.
- PIPE_STAGES, 2: register stages from input to output; must be ≥1.
- PRODUCT_WIDTH, DATA_WIDTH: width of each saturated result lane; must be ≤2*DATA_WIDTH-FRAC_BITS.

Ports:
- clk_in, input, 1: clock; all state is updated on the rising edge.
- rst_in, input, 1: asynchronous, active-high reset.
- in_valid_in, input, 1: the input beat is valid.
- in_ready_out, output, 1: the block accepts the input beat this cycle.
- multiplicand_in, input, NUM_LANES*DATA_WIDTH: lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- multiplier_in, input, NUM_LANES*DATA_WIDTH: packed the same way as multiplicand_in.
- out_valid_out, output, 1: the output beat is valid.
- out_ready_in, input, 1: the downstream block accepts the output beat.
- product_out, output, NUM_LANES*PRODUCT_WIDTH: saturated products, packed per lane.
- lane_sat_out, output, NUM_LANES: bit i is set when lane i of the current output beat was saturated.
- sat_sticky_out, output, 1: set if any saturated beat has transferred since the last clear.
- sat_clear_in, input, 1: synchronous clear for sat_sticky_out.

## Operation
- Input transfer happens when in_valid_in && in_ready_out. Output transfer happens when out_valid_out && out_ready_in.
- Global enable: en = !out_valid_out || out_ready_in.
  - in_ready_out = en. This is a combinational path from out_ready_in.
  - When en=0, every stage register (data and valid) holds its value.
  - Bubbles are not compressed.
- Stage 1 registers the full 2*DATA_WIDTH-bit signed product of each lane and the beat's valid bit (in_valid_in when en=1).
- Rectification is combinational on the stage-1 output, in this order:
  1. Arithmetic shift right by FRAC_BITS, with optional rounding (see Configuration).
  2. Saturate to PRODUCT_WIDTH. Values above 2^(PRODUCT_WIDTH-1)-1 clamp to the maximum; values below -2^(PRODUCT_WIDTH-1) clamp to the minimum.
  3. Set the lane's saturation bit when clamping occurred.
- Stages 2..PIPE_STAGES carry the rectified lanes, the saturation bits and the valid bit.
  - The last stage drives product_out, lane_sat_out and out_valid_out.
  - When PIPE_STAGES=1, these outputs are the rectifier output of stage 1.
- sat_sticky_out:
  - Set on an output transfer with |lane_sat_out.
  - Cleared by sat_clear_in.
  - When set and clear occur in the same cycle, set wins.
- Lanes are fully independent; there is no cross-lane arithmetic.

## Timing
- Latency is PIPE_STAGES cycles from input transfer to out_valid_out, when no stall occurs.
- Throughput is one beat per cycle while out_ready_in=1.
- out_valid_out, product_out and lane_sat_out are stable while out_valid_out && !out_ready_in.
- Reset values: every stage valid bit = 0, every data register = 0, out_valid_out = 0, product_out = 0, lane_sat_out = 0, sat_sticky_out = 0.
  - in_ready_out = 1 after reset, because out_valid_out = 0.
- Reset mid-operation discards all in-flight beats immediately. No partial beat is emitted.
- If in_valid_in=0 while en=1, a bubble (valid=0) enters stage 1. Stage-1 data is don't-care but is still registered.
- The output stage accepts a new beat in the same cycle it transfers the held beat out, with no dead cycle.

## Configuration
- FXP_MUL_ROUND_EN defined: round-half-up. 2^(FRAC_BITS-1) is added to the raw product before the arithmetic shift, in a 2*DATA_WIDTH+1-bit intermediate so the addition cannot wrap. Saturation is applied after rounding.
- FXP_MUL_ROUND_EN undefined: truncation by plain arithmetic shift (floor). No adder is instantiated.

## Test plan
All values are in the default Q5.10 format with PIPE_STAGES=2.
- Basic multiply: lane0 0x0600*0x0800 (1.5×2.0), out_ready_in=1 → product 0x0C00 two cycles after transfer; lane_sat_out[0]=0.
- Positive saturation: 0x7FFF*0x7FFF → 0x7FFF, lane_sat_out[0]=1, and sat_sticky_out=1 the cycle after output transfer. Negative saturation: 0x8000*0x7FFF → 0x8000, sat bit set.
- Rounding: 0x0001*0x0200 → 0x0001 with FXP_MUL_ROUND_EN, 0x0000 without. 0xFFFF*0x0200 → 0x0000 with the macro, 0xFFFF without.
- Backpressure: stream 8 beats with distinct per-lane values and hold out_ready_in=0 for 3 cycles mid-stream → in_ready_out=0 during the stall, output held stable, all 8 beats emitted in order with none lost or duplicated.
- Sticky flag: saturated beat transfers in the same cycle sat_clear_in=1 → sat_sticky_out stays 1. Next cycle sat_clear_in=1 with no saturating transfer → sat_sticky_out=0.
- Reset mid-stream: assert rst_in with 2 beats in flight → out_valid_out=0, product_out=0 and sat_sticky_out=0 immediately; no stale beat appears after release.
